// File: rtl/count_pkg.sv
// Shared constants for the count_gen counter family: run-state encoding and boundary modes.
package count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/count_next.sv
// Next-count decode: step/wrap/saturate value plus boundary event and blocked-step flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; en only gates whether a step is taken.
module count_next
    import count_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter int              SAT_MODE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             up,
    input  logic             en,
    output logic [WIDTH-1:0] nxt,
    output logic             evt,
    output logic             blocked
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic at_max;
    logic at_zero;
    logic boundary;

    assign at_max   = (cnt == MAX_V);
    assign at_zero  = (cnt == '0);
    assign boundary = up ? at_max : at_zero;
    assign evt      = en && boundary;
    assign blocked  = evt && (SAT_MODE == MODE_SAT);

    always_comb begin
        nxt = cnt;
        if (en) begin
            if (boundary) begin
                // Saturating mode holds the boundary; wrap mode jumps to the opposite end.
                if (SAT_MODE == MODE_SAT)
                    nxt = cnt;
                else
                    nxt = up ? '0 : MAX_V;
            end else begin
                nxt = up ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/count_gen.sv
// Up/down counter with programmable terminal value, wrap/saturate mode, sticky overflow and run-state FSM.
// Latency: one cycle from edge to new CNT/OVF/ST; TC is a combinational decode of CNT and live up.
// Backpressure: none; res > load > EN priority each edge, clr_ovf independent (set beats clear).
module count_gen
    import count_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter int              SAT_MODE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic             load,
    input  logic             up,
    input  logic             clr_ovf,
    input  logic [WIDTH-1:0] CNT_In,
    output logic [WIDTH-1:0] CNT,
    output logic             TC,
    output logic             OVF,
    output logic [1:0]       ST
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q;
    logic             ovf_q;
    state_t           state;

    logic [WIDTH-1:0] nxt;
    logic             evt;
    logic             blocked;
    logic [WIDTH-1:0] load_val;

    count_next #(
        .WIDTH    (WIDTH),
        .MAX      (MAX),
        .SAT_MODE (SAT_MODE)
    ) u_next (
        .cnt     (cnt_q),
        .up      (up),
        .en      (EN),
        .nxt     (nxt),
        .evt     (evt),
        .blocked (blocked)
    );

    assign load_val = (CNT_In > MAX_V) ? MAX_V : CNT_In;

    always_ff @(posedge clk) begin
        if (!res) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            state <= ST_IDLE;
        end else begin
            if (load) begin
                cnt_q <= load_val;
                state <= ST_IDLE;
            end else if (EN) begin
                cnt_q <= nxt;
                if (blocked)
                    state <= ST_HOLD;
                else
                    state <= up ? ST_UP : ST_DOWN;
            end else begin
                state <= ST_IDLE;
            end

            // A load masks the boundary event, so it can never set the sticky flag.
            if (evt && !load)
                ovf_q <= 1'b1;
            else if (clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    assign CNT = cnt_q;
    assign OVF = ovf_q;
    assign ST  = state;
    assign TC  = (up && (cnt_q == MAX_V)) || (!up && (cnt_q == '0));

endmodule

// File: tb/tb_count_gen.sv
// Four count_gen instances (legacy wrap, small wrap, saturate, clamp) driven from shared stimulus.
module tb_count_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res, en, load, up, clr_ovf;
    logic [7:0] cnt_in;

    logic [7:0] cnt_a, cnt_c, cnt_d;
    logic [3:0] cnt_b;
    logic       tc_a, tc_b, tc_c, tc_d;
    logic       ovf_a, ovf_b, ovf_c, ovf_d;
    logic [1:0] st_a, st_b, st_c, st_d;

    count_gen #(.WIDTH(8), .MAX(255), .SAT_MODE(0)) dut_a (
        .clk(clk), .res(res), .EN(en), .load(load), .up(up), .clr_ovf(clr_ovf),
        .CNT_In(cnt_in), .CNT(cnt_a), .TC(tc_a), .OVF(ovf_a), .ST(st_a));
    count_gen #(.WIDTH(4), .MAX(9), .SAT_MODE(0)) dut_b (
        .clk(clk), .res(res), .EN(en), .load(load), .up(up), .clr_ovf(clr_ovf),
        .CNT_In(cnt_in[3:0]), .CNT(cnt_b), .TC(tc_b), .OVF(ovf_b), .ST(st_b));
    count_gen #(.WIDTH(8), .MAX(200), .SAT_MODE(1)) dut_c (
        .clk(clk), .res(res), .EN(en), .load(load), .up(up), .clr_ovf(clr_ovf),
        .CNT_In(cnt_in), .CNT(cnt_c), .TC(tc_c), .OVF(ovf_c), .ST(st_c));
    count_gen #(.WIDTH(8), .MAX(100), .SAT_MODE(0)) dut_d (
        .clk(clk), .res(res), .EN(en), .load(load), .up(up), .clr_ovf(clr_ovf),
        .CNT_In(cnt_in), .CNT(cnt_d), .TC(tc_d), .OVF(ovf_d), .ST(st_d));

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // Reference model: per-instance terminal value, mode and load mask.
    int mx[4]  = '{255, 9, 200, 100};
    int sat[4] = '{0, 0, 1, 0};
    int msk[4] = '{255, 15, 255, 255};
    int m_cnt[4];
    int m_ovf[4];
    int m_st[4];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_tc(input int i);
        return ((up && m_cnt[i] == mx[i]) || (!up && m_cnt[i] == 0)) ? 1 : 0;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            if (!res) begin
                m_cnt[i] = 0;
                m_ovf[i] = 0;
                m_st[i]  = 0;
            end else begin
                bit hit;
                hit = en && !load && ((up && m_cnt[i] == mx[i]) || (!up && m_cnt[i] == 0));
                if (load) begin
                    m_cnt[i] = ((cnt_in & msk[i]) > mx[i]) ? mx[i] : (cnt_in & msk[i]);
                    m_st[i]  = 0;
                end else if (en) begin
                    if (hit)
                        m_cnt[i] = sat[i] ? m_cnt[i] : (up ? 0 : mx[i]);
                    else
                        m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
                    m_st[i] = (sat[i] && hit) ? 3 : (up ? 1 : 2);
                end else begin
                    m_st[i] = 0;
                end
                if (hit)
                    m_ovf[i] = 1;
                else if (clr_ovf)
                    m_ovf[i] = 0;
            end
        end
    endtask

    task automatic chk_inst(input int i, input string n, input logic [31:0] c,
                            input logic t, input logic o, input logic [1:0] s);
        cmp({n, ".cnt"}, c, m_cnt[i]);
        cmp({n, ".tc"}, {31'd0, t}, m_tc(i));
        cmp({n, ".ovf"}, {31'd0, o}, m_ovf[i]);
        cmp({n, ".st"}, {30'd0, s}, m_st[i]);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk_inst(0, "A", cnt_a, tc_a, ovf_a, st_a);
            chk_inst(1, "B", cnt_b, tc_b, ovf_b, st_b);
            chk_inst(2, "C", cnt_c, tc_c, ovf_c, st_c);
            chk_inst(3, "D", cnt_d, tc_d, ovf_d, st_d);
        end
    end

    task automatic cycle(input bit r, input bit e, input bit l, input bit u, input bit c,
                         input logic [7:0] v);
        res = r; en = e; load = l; up = u; clr_ovf = c; cnt_in = v;
        @(posedge clk);
        model_step();
        #2;
    endtask

    initial begin
        bit r, e, l, u, c;
        res = 1'b0; en = 1'b0; load = 1'b0; up = 1'b1; clr_ovf = 1'b0; cnt_in = '0;

        // Legacy equivalence on instance A
        cycle(0, 0, 0, 1, 0, 0);
        checking = 1'b1;
        cmp("rst_cnt", cnt_a, 0);
        cmp("rst_ovf", ovf_a, 0);
        cmp("rst_st", st_a, 0);
        cmp("rst_tc_up", tc_a, 0);
        repeat (4) cycle(1, 1, 0, 1, 0, 0);
        cmp("legacy_cnt4", cnt_a, 4);
        repeat (2) cycle(1, 1, 1, 1, 0, 8'h11);
        cmp("legacy_load", cnt_a, 8'h11);
        repeat (5) cycle(1, 0, 0, 1, 0, 0);
        cmp("legacy_hold", cnt_a, 8'h11);
        cmp("legacy_idle", st_a, 0);

        // Wrap up on B (MAX=9)
        cycle(1, 0, 1, 1, 0, 8);
        cmp("wrapup_load", cnt_b, 8);
        cycle(1, 1, 0, 1, 0, 0);
        cmp("wrapup_9", cnt_b, 9);
        cmp("wrapup_tc", tc_b, 1);
        cycle(1, 1, 0, 1, 0, 0);
        cmp("wrapup_0", cnt_b, 0);
        cmp("wrapup_ovf", ovf_b, 1);
        cycle(1, 1, 0, 1, 0, 0);
        cmp("wrapup_1", cnt_b, 1);

        // Wrap down on B
        cycle(1, 0, 1, 0, 1, 0);
        cmp("wrapdn_tc", tc_b, 1);
        cmp("wrapdn_clr", ovf_b, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cmp("wrapdn_9", cnt_b, 9);
        cmp("wrapdn_ovf", ovf_b, 1);
        cycle(1, 0, 0, 0, 1, 0);
        cmp("wrapdn_clr2", ovf_b, 0);

        // Saturate on C (MAX=200)
        cycle(1, 0, 1, 1, 1, 199);
        cmp("sat_load", cnt_c, 199);
        cmp("sat_ovf0", ovf_c, 0);
        repeat (3) begin
            cycle(1, 1, 0, 1, 0, 0);
            cmp("sat_200", cnt_c, 200);
        end
        cmp("sat_hold", st_c, 3);
        cmp("sat_ovf", ovf_c, 1);
        cycle(1, 1, 0, 0, 0, 0);
        cmp("sat_199", cnt_c, 199);
        cmp("sat_down", st_c, 2);

        // Load clamp and priority on D (MAX=100)
        cycle(1, 0, 0, 1, 1, 0);
        cycle(1, 1, 1, 1, 0, 150);
        cmp("clamp_cnt", cnt_d, 100);
        cmp("clamp_ovf", ovf_d, 0);
        cmp("clamp_st", st_d, 0);
        cycle(0, 1, 1, 1, 0, 150);
        cmp("prio_cnt", cnt_d, 0);
        cmp("prio_st", st_d, 0);

        // Simultaneous set/clear on B
        cycle(1, 0, 1, 1, 0, 9);
        cycle(1, 1, 0, 1, 1, 0);
        cmp("setclr_cnt", cnt_b, 0);
        cmp("setclr_ovf", ovf_b, 1);
        cycle(1, 0, 0, 1, 1, 0);
        cmp("clr_only", ovf_b, 0);

        // Randomised traffic; direction is sticky so counters reach their boundaries
        u = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            r = ($urandom_range(0, 63) != 0);
            e = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 11) == 0);
            c = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) u = ~u;
            cycle(r, e, l, u, c, 8'($urandom_range(0, 255)));
        end

        @(negedge clk);
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
